// File: rtl/pipeline_step_controller_pkg.sv
// Shared types and default sizing for the pipeline step controller.
package pipe_ctrl_pkg;
  localparam int CNT_W           = 28;
  localparam int DEFAULT_DIVISOR = 500000;
  localparam int ADV_CNT_W       = 16;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/pipeline_step_controller_if.sv
// Control/config handshake and advance outputs of one pipeline step controller.
interface pipeline_step_controller_if #(
  parameter int CNT_W     = pipe_ctrl_pkg::CNT_W,
  parameter int ADV_CNT_W = pipe_ctrl_pkg::ADV_CNT_W
) ();
  logic                     cfg_valid;
  logic [CNT_W-1:0]         cfg_divisor;
  logic                     cfg_ready;
  logic                     run_req;
  logic                     halt_req;
  logic                     step_req;
  logic                     stall;
  logic                     adv;
  logic                     phase;
  pipe_ctrl_pkg::ctrl_state_t state_o;
  logic [ADV_CNT_W-1:0]     adv_count;

  modport master (
    output cfg_valid, cfg_divisor, run_req, halt_req, step_req, stall,
    input  cfg_ready, adv, phase, state_o, adv_count
  );

  modport slave (
    input  cfg_valid, cfg_divisor, run_req, halt_req, step_req, stall,
    output cfg_ready, adv, phase, state_o, adv_count
  );
endinterface

// File: rtl/pipeline_step_controller_counter.sv
// Period counter: counts 0..divisor-1, flags the terminal cycle, holds at terminal under stall.
module pipe_period_counter #(
  parameter int CNT_W = pipe_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             stall,
  input  logic [CNT_W-1:0] divisor,
  output logic             terminal,
  output logic             phase
);
  logic [CNT_W-1:0] count_q, count_d;
  logic             at_end;

  // >= keeps the counter from running away if it ever sits past the end
  assign at_end   = (count_q >= (divisor - CNT_W'(1)));
  assign terminal = enable && at_end && !stall;
  assign phase    = enable && (count_q < (divisor >> 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (at_end) begin
        if (!stall) count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/pipeline_step_controller.sv
// Issues single-cycle advance strobes at a programmable rate: free-run, single-step, halt, stall-aware.
module pipeline_step_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W           = pipe_ctrl_pkg::CNT_W,
  parameter int DEFAULT_DIVISOR = pipe_ctrl_pkg::DEFAULT_DIVISOR,
  parameter int ADV_CNT_W       = pipe_ctrl_pkg::ADV_CNT_W
) (
  input  logic                        clock_in,
  input  logic                        reset,
  pipeline_step_controller_if.slave   bus
);
  ctrl_state_t          state_q, state_d;
  logic [CNT_W-1:0]     divisor_q, divisor_d;
  logic                 adv_q, adv_d;
  logic [ADV_CNT_W-1:0] adv_count_q, adv_count_d;
  logic                 step_prev_q;
  logic                 step_edge;
  logic                 cnt_enable, cnt_clear, terminal, cnt_phase;

  assign step_edge  = bus.step_req && !step_prev_q;
  assign cnt_enable = (state_q != HALT);
  assign cnt_clear  = (state_q == HALT) || bus.halt_req;

  pipe_period_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clock_in),
    .rst      (reset),
    .enable   (cnt_enable),
    .clear    (cnt_clear),
    .stall    (bus.stall),
    .divisor  (divisor_q),
    .terminal (terminal),
    .phase    (cnt_phase)
  );

  // Request priority is halt > run > step edge in every state
  always_comb begin
    state_d = state_q;
    adv_d   = 1'b0;
    case (state_q)
      HALT: begin
        if (!bus.halt_req) begin
          if (bus.run_req)    state_d = RUN;
          else if (step_edge) state_d = STEP;
        end
      end
      RUN: begin
        if (bus.halt_req) state_d = HALT;
        else              adv_d   = terminal;
      end
      STEP: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else begin
          adv_d = terminal;
          if (bus.run_req)   state_d = RUN;
          else if (terminal) state_d = HALT;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    divisor_d = divisor_q;
    if (bus.cfg_valid && (state_q == HALT)) begin
      divisor_d = (bus.cfg_divisor == '0) ? CNT_W'(1) : bus.cfg_divisor;
    end
    adv_count_d = adv_count_q + {{(ADV_CNT_W-1){1'b0}}, adv_d};
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= HALT;
      divisor_q   <= CNT_W'(DEFAULT_DIVISOR);
      adv_q       <= 1'b0;
      adv_count_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      adv_q       <= adv_d;
      adv_count_q <= adv_count_d;
      step_prev_q <= bus.step_req;
    end
  end

  assign bus.cfg_ready = (state_q == HALT);
  assign bus.adv       = adv_q;
  assign bus.phase     = cnt_phase;
  assign bus.state_o   = state_q;
  assign bus.adv_count = adv_count_q;
endmodule

// File: tb/tb_pipeline_step_controller.sv
// Self-checking bench: directed scenarios plus randomized run against a cycle-level behavioural model.
module tb_pipeline_step_controller;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  pipeline_step_controller_if bus ();

  pipeline_step_controller dut (
    .clock_in (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.cfg_valid   = 1'b0;
    bus.cfg_divisor = '0;
    bus.run_req     = 1'b0;
    bus.halt_req    = 1'b0;
    bus.step_req    = 1'b0;
    bus.stall       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_divisor(input int d);
    bus.cfg_valid   = 1'b1;
    bus.cfg_divisor = 28'(d);
    cycle();
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic enter_run();
    bus.run_req = 1'b1;
    cycle();
    bus.run_req = 1'b0;
  endtask

  task automatic go_halt();
    bus.halt_req = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      fails++; $display("FAIL reset_cfg_ready_during: got %b want 1", bus.cfg_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.state_o !== HALT) begin
      fails++; $display("FAIL reset_state: got %0d want %0d", bus.state_o, HALT);
    end
    checks++;
    if (bus.adv !== 1'b0 || bus.phase !== 1'b0) begin
      fails++; $display("FAIL reset_adv_phase: got adv=%b phase=%b want 0/0", bus.adv, bus.phase);
    end
    checks++;
    if (bus.adv_count !== 16'd0) begin
      fails++; $display("FAIL reset_adv_count: got %0d want 0", bus.adv_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_cfg_run();
    bus.cfg_valid   = 1'b1;
    bus.cfg_divisor = 28'd4;
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      fails++; $display("FAIL cfg_ready_halt: got %b want 1", bus.cfg_ready);
    end
    cycle();
    bus.cfg_valid = 1'b0;
    enter_run();
    checks++;
    if (bus.state_o !== RUN) begin
      fails++; $display("FAIL run_entry_state: got %0d want %0d", bus.state_o, RUN);
    end
    for (int k = 0; k <= 12; k++) begin
      checks++;
      if (bus.adv !== ((k % 4 == 0) && (k > 0))) begin
        fails++; $display("FAIL div4_adv k=%0d: got %b want %b", k, bus.adv, (k % 4 == 0) && (k > 0));
      end
      checks++;
      if (bus.phase !== (k % 4 < 2)) begin
        fails++; $display("FAIL div4_phase k=%0d: got %b want %b", k, bus.phase, (k % 4 < 2));
      end
      if (k < 12) cycle();
    end
    checks++;
    if (bus.adv_count !== 16'd3) begin
      fails++; $display("FAIL div4_adv_count: got %0d want 3", bus.adv_count);
    end
    go_halt();
    $display("test_cfg_run done");
  endtask

  task automatic test_div1_wrap();
    int n = 0;
    int cyc = 0;
    int gaps = 0;
    do_reset();
    load_divisor(1);
    enter_run();
    while (n < 70000 && cyc < 70100) begin
      cycle();
      cyc++;
      if (bus.adv === 1'b1) n++;
      else gaps++;
    end
    checks++;
    if (n != 70000) begin
      fails++; $display("FAIL div1_pulses: got %0d want 70000 within bound", n);
    end
    checks++;
    if (gaps != 0) begin
      fails++; $display("FAIL div1_every_cycle: got %0d idle cycles want 0", gaps);
    end
    checks++;
    if (bus.adv_count !== 16'd4464) begin
      fails++; $display("FAIL div1_adv_count: got %0d want 4464", bus.adv_count);
    end
    go_halt();
    $display("test_div1_wrap done");
  endtask

  task automatic test_stall();
    load_divisor(5);
    enter_run();
    for (int k = 0; k <= 14; k++) begin
      checks++;
      if (bus.adv !== (k == 8 || k == 13)) begin
        fails++; $display("FAIL stall_adv k=%0d: got %b want %b", k, bus.adv, (k == 8 || k == 13));
      end
      bus.stall = (k >= 4 && k <= 6);
      cycle();
    end
    bus.stall = 1'b0;
    go_halt();
    $display("test_stall done");
  endtask

  task automatic test_step();
    do_reset();
    load_divisor(3);
    bus.step_req = 1'b1;
    cycle();
    // s counts cycles from the one in which state_o first shows STEP
    for (int s = 0; s < 10; s++) begin
      checks++;
      if (bus.adv !== (s == 3)) begin
        fails++; $display("FAIL step_adv s=%0d: got %b want %b", s, bus.adv, (s == 3));
      end
      checks++;
      if (bus.state_o !== ((s < 3) ? STEP : HALT)) begin
        fails++; $display("FAIL step_state s=%0d: got %0d want %0d", s, bus.state_o, (s < 3) ? STEP : HALT);
      end
      cycle();
    end
    bus.step_req = 1'b0;
    cycle();
    cycle();
    bus.step_req = 1'b1;
    for (int s = 0; s < 6; s++) cycle();
    bus.step_req = 1'b0;
    checks++;
    if (bus.adv_count !== 16'd2 || bus.state_o !== HALT) begin
      fails++; $display("FAIL step_second: got count=%0d state=%0d want 2/%0d", bus.adv_count, bus.state_o, HALT);
    end
    $display("test_step done");
  endtask

  task automatic test_halt_abort();
    load_divisor(6);
    enter_run();
    for (int k = 0; k < 5; k++) cycle();
    bus.halt_req = 1'b1;
    bus.run_req  = 1'b1;
    cycle();
    bus.halt_req = 1'b0;
    bus.run_req  = 1'b0;
    checks++;
    if (bus.state_o !== HALT || bus.adv !== 1'b0 || bus.phase !== 1'b0) begin
      fails++; $display("FAIL halt_abort: got state=%0d adv=%b phase=%b want %0d/0/0", bus.state_o, bus.adv, bus.phase, HALT);
    end
    enter_run();
    for (int k = 0; k <= 12; k++) begin
      bus.cfg_valid   = (k == 1 || k == 2);
      bus.cfg_divisor = 28'd2;
      if (k == 1) begin
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
          fails++; $display("FAIL cfg_ready_run: got %b want 0", bus.cfg_ready);
        end
      end
      checks++;
      if (bus.adv !== (k == 6 || k == 12)) begin
        fails++; $display("FAIL div_unchanged_adv k=%0d: got %b want %b", k, bus.adv, (k == 6 || k == 12));
      end
      cycle();
    end
    bus.cfg_valid = 1'b0;
    go_halt();
    $display("test_halt_abort done");
  endtask

  task automatic test_async_reset();
    load_divisor(3);
    bus.step_req = 1'b1;
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.state_o !== HALT || bus.adv !== 1'b0 || bus.phase !== 1'b0) begin
      fails++; $display("FAIL async_reset_outputs: got state=%0d adv=%b phase=%b want %0d/0/0", bus.state_o, bus.adv, bus.phase, HALT);
    end
    checks++;
    if (bus.adv_count !== 16'd0 || bus.cfg_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset_count_ready: got count=%0d ready=%b want 0/1", bus.adv_count, bus.cfg_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.step_req = 1'b0;
    enter_run();
    // with the 500000 default, phase stays high and no adv for a long time
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (bus.phase !== 1'b1 || bus.adv !== 1'b0) begin
        fails++; $display("FAIL default_divisor k=%0d: got phase=%b adv=%b want 1/0", k, bus.phase, bus.adv);
      end
      cycle();
    end
    go_halt();
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    ctrl_state_t m_state, ns;
    int          m_pos, m_div, npos;
    bit          m_prev, m_adv, m_term, m_edge;
    logic [15:0] m_count;
    do_reset();
    m_state = HALT; m_pos = 0; m_div = DEFAULT_DIVISOR;
    m_prev = 1'b0; m_adv = 1'b0; m_count = '0;
    for (int c = 0; c < 1500; c++) begin
      bus.halt_req    = ($urandom_range(0, 15) == 0);
      bus.run_req     = ($urandom_range(0, 7) == 0);
      bus.step_req    = ($urandom_range(0, 2) == 0);
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.cfg_valid   = ($urandom_range(0, 3) == 0);
      bus.cfg_divisor = 28'($urandom_range(0, 6));
      @(posedge clk);
      // model: position within the period, advanced by the spec rules
      m_edge = bus.step_req && !m_prev;
      m_term = (m_state != HALT) && (m_pos == m_div - 1) && !bus.stall;
      ns = m_state; npos = m_pos; m_adv = 1'b0;
      if (m_state == HALT) begin
        npos = 0;
        if (bus.cfg_valid) m_div = (bus.cfg_divisor == 0) ? 1 : int'(bus.cfg_divisor);
        if (!bus.halt_req) begin
          if (bus.run_req) ns = RUN;
          else if (m_edge) ns = STEP;
        end
      end else if (bus.halt_req) begin
        ns = HALT; npos = 0;
      end else begin
        m_adv = m_term;
        if (m_pos == m_div - 1) npos = bus.stall ? m_pos : 0;
        else                    npos = m_pos + 1;
        if (m_state == STEP) begin
          if (bus.run_req) ns = RUN;
          else if (m_term) ns = HALT;
        end
      end
      m_state = ns; m_pos = npos; m_prev = bus.step_req;
      if (m_adv) m_count = m_count + 16'd1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== m_state) begin
        fails++; $display("FAIL rand_state c=%0d: got %0d want %0d", c, bus.state_o, m_state);
      end
      checks++;
      if (bus.adv !== m_adv) begin
        fails++; $display("FAIL rand_adv c=%0d: got %b want %b", c, bus.adv, m_adv);
      end
      checks++;
      if (bus.phase !== ((m_state != HALT) && (m_pos < m_div / 2))) begin
        fails++; $display("FAIL rand_phase c=%0d: got %b want %b", c, bus.phase, (m_state != HALT) && (m_pos < m_div / 2));
      end
      checks++;
      if (bus.cfg_ready !== (m_state == HALT)) begin
        fails++; $display("FAIL rand_cfg_ready c=%0d: got %b want %b", c, bus.cfg_ready, m_state == HALT);
      end
      checks++;
      if (bus.adv_count !== m_count) begin
        fails++; $display("FAIL rand_adv_count c=%0d: got %0d want %0d", c, bus.adv_count, m_count);
      end
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_cfg_run();
    test_div1_wrap();
    test_stall();
    test_step();
    test_halt_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
